// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store unit.
// Holds funct3 encodings, FSM states and size/legality decode.
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        SECOND,
        RESP
    } lsu_state_e;

    function automatic logic [2:0] size_of(input logic [2:0] f3);
        case (f3)
            LB, LBU: return 3'd1;
            LH, LHU: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic illegal(input logic we,
                                     input logic [2:0] f3);
        if (we)
            return !(f3 == SB || f3 == SH || f3 == SW);
        return !(f3 == LB || f3 == LH || f3 == LW ||
                 f3 == LBU || f3 == LHU);
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response handshake bundle between execute and the LSU.
// master = execute side, slave = load/store unit.
interface lsu_if;

    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [2:0]  i_req_funct3;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;

    modport master (
        output i_req_valid, i_req_we, i_req_funct3,
        output i_req_addr, i_req_wdata,
        input  o_req_ready, o_rsp_valid,
        input  o_rsp_rdata, o_rsp_err
    );

    modport slave (
        input  i_req_valid, i_req_we, i_req_funct3,
        input  i_req_addr, i_req_wdata,
        output o_req_ready, o_rsp_valid,
        output o_rsp_rdata, o_rsp_err
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane mask, store alignment and load extraction.
// Works on a 64-bit two-word window so split accesses need no special case.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_size,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_lo,
    input  logic [31:0] i_hi,
    output logic [7:0]  o_m8,
    output logic [63:0] o_d64,
    output logic [31:0] o_ldata
);

    logic [7:0]  w_lanes;
    logic [5:0]  w_sh;
    logic [31:0] w_v;

    always_comb begin
        w_lanes = 8'h0F;
        unique case (1'b1)
            (i_size == 3'd1): w_lanes = 8'h01;
            (i_size == 3'd2): w_lanes = 8'h03;
            default:          w_lanes = 8'h0F;
        endcase
    end

    assign w_sh  = {1'b0, i_off, 3'b000};
    assign o_m8  = w_lanes << i_off;
    assign o_d64 = {32'b0, i_wdata} << w_sh;
    assign w_v   = 32'({i_hi, i_lo} >> w_sh);

    always_comb begin
        o_ldata = '0;
        case (i_funct3)
            LB:      o_ldata = {{24{w_v[7]}}, w_v[7:0]};
            LH:      o_ldata = {{16{w_v[15]}}, w_v[15:0]};
            LW:      o_ldata = w_v;
            LBU:     o_ldata = {24'b0, w_v[7:0]};
            LHU:     o_ldata = {16'b0, w_v[15:0]};
            default: o_ldata = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, split across two memory
// cycles when the access straddles a word boundary.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_AW = 9
) (
    input  logic              i_clk,
    input  logic              i_reset,
    lsu_if.slave              bus,
    output logic              o_mem_wren,
    output logic [3:0]        o_mem_bmask,
    output logic [MEM_AW-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata
);

    lsu_state_e          r_state;
    lsu_state_e          w_next;
    logic                r_we;
    logic [2:0]          r_f3;
    logic [MEM_AW+1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_lo;
    logic [31:0]         r_hi;
    logic                r_err;

    logic                w_hs;
    logic [2:0]          w_in_size;
    logic                w_in_split;
    logic                w_req_err;
    logic [2:0]          w_size;
    logic [1:0]          w_off;
    logic [MEM_AW-1:0]   w_w0;
    logic                w_split;
    logic [7:0]          w_m8;
    logic [63:0]         w_d64;
    logic [31:0]         w_ldata;

    assign w_hs      = bus.i_req_valid & bus.o_req_ready;
    assign w_in_size = size_of(bus.i_req_funct3);
    assign w_in_split = ({2'b00, bus.i_req_addr[1:0]} +
                         {1'b0, w_in_size}) > 4'd4;

    // A split at the last word would touch a byte past the memory.
    assign w_req_err = illegal(bus.i_req_we, bus.i_req_funct3) |
                       (|bus.i_req_addr[31:MEM_AW+2]) |
                       (w_in_split & (&bus.i_req_addr[MEM_AW+1:2]));

    assign w_size  = size_of(r_f3);
    assign w_off   = r_addr[1:0];
    assign w_w0    = r_addr[MEM_AW+1:2];
    assign w_split = ({2'b00, w_off} + {1'b0, w_size}) > 4'd4;

    lsu_align u_align (
        .i_off    (w_off),
        .i_size   (w_size),
        .i_funct3 (r_f3),
        .i_wdata  (r_wdata),
        .i_lo     (r_lo),
        .i_hi     (r_hi),
        .o_m8     (w_m8),
        .o_d64    (w_d64),
        .o_ldata  (w_ldata)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_we    <= 1'b0;
            r_f3    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_hs) begin
                r_we    <= bus.i_req_we;
                r_f3    <= bus.i_req_funct3;
                r_addr  <= bus.i_req_addr[MEM_AW+1:0];
                r_wdata <= bus.i_req_wdata;
                r_err   <= w_req_err;
                r_hi    <= '0;
            end
            if (r_state == FIRST)
                r_lo <= i_mem_rdata;
            if (r_state == SECOND)
                r_hi <= i_mem_rdata;
        end
    end

    always_comb begin
        w_next          = r_state;
        bus.o_req_ready = 1'b0;
        bus.o_rsp_valid = 1'b0;
        bus.o_rsp_rdata = '0;
        bus.o_rsp_err   = 1'b0;
        o_mem_wren      = 1'b0;
        o_mem_bmask     = '0;
        o_mem_addr      = '0;
        o_mem_wdata     = '0;
        case (r_state)
            IDLE: begin
                bus.o_req_ready = 1'b1;
                if (bus.i_req_valid)
                    w_next = w_req_err ? RESP : FIRST;
            end
            FIRST: begin
                o_mem_wren  = r_we;
                o_mem_bmask = w_m8[3:0];
                o_mem_addr  = w_w0;
                o_mem_wdata = w_d64[31:0];
                w_next      = w_split ? SECOND : RESP;
            end
            SECOND: begin
                o_mem_wren  = r_we;
                o_mem_bmask = w_m8[7:4];
                o_mem_addr  = w_w0 + MEM_AW'(1);
                o_mem_wdata = w_d64[63:32];
                w_next      = RESP;
            end
            RESP: begin
                bus.o_rsp_valid = 1'b1;
                bus.o_rsp_err   = r_err;
                bus.o_rsp_rdata = (r_err | r_we) ? '0 : w_ldata;
                w_next          = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit against a byte-level memory model.
// Directed cases plus a random mix of loads/stores.
module tb_load_store_unit;

    localparam int AW = 9;
    localparam int NW = 1 << AW;
    localparam int NB = NW * 4;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [3:0]    m;
        logic [31:0]   d;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mem_wren;
    logic [3:0]    mem_bmask;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic [31:0]   mem [NW];
    logic [7:0]    bm [NB];
    bit            seeded = 1'b0;
    exp_t          sb [$];
    wr_t           wlog [$];
    int            n_vec = 0;
    int            n_bad = 0;

    always #5 clk = ~clk;

    lsu_if bus ();

    load_store_unit #(.MEM_AW(AW)) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .bus         (bus),
        .o_mem_wren  (mem_wren),
        .o_mem_bmask (mem_bmask),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata)
    );

    function automatic logic [31:0] seed_w(int i);
        return 32'(32'h9E3779B9 * (i + 1));
    endfunction

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < NW; i++) mem[i] <= seed_w(i);
            seeded <= 1'b1;
        end else if (mem_wren) begin
            wlog.push_back('{mem_addr, mem_bmask, mem_wdata});
            for (int b = 0; b < 4; b++)
                if (mem_bmask[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic ref_op(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output exp_t e);
        int s;
        logic bad;
        logic [31:0] v;
        if (we) bad = !(f3 inside {3'b000, 3'b001, 3'b010});
        else    bad = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        s = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        if (longint'(addr) + s > NB) bad = 1'b1;
        e.err = bad;
        e.rd  = '0;
        e.lat = bad ? 1 : ((int'(addr[1:0]) + s > 4) ? 3 : 2);
        if (!bad && we) begin
            for (int i = 0; i < s; i++) bm[int'(addr) + i] = wd[8*i +: 8];
        end else if (!bad) begin
            v = '0;
            for (int i = 0; i < s; i++) v[8*i +: 8] = bm[int'(addr) + i];
            if (f3 == 3'b000) v = {{24{v[7]}}, v[7:0]};
            if (f3 == 3'b001) v = {{16{v[15]}}, v[15:0]};
            e.rd = v;
        end
    endtask

    task automatic access(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        int   lat;
        bit   got;
        ref_op(we, f3, addr, wd, e);
        sb.push_back(e);
        @(negedge clk);
        check("ready_idle", {31'b0, bus.o_req_ready}, 32'd1);
        bus.i_req_valid  = 1'b1;
        bus.i_req_we     = we;
        bus.i_req_funct3 = f3;
        bus.i_req_addr   = addr;
        bus.i_req_wdata  = wd;
        @(posedge clk);
        #1;
        bus.i_req_valid = 1'b0;
        check("ready_busy", {31'b0, bus.o_req_ready}, 32'd0);
        got = 1'b0;
        lat = 0;
        for (int c = 1; c <= 6 && !got; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (bus.o_rsp_valid) begin
                got = 1'b1;
                lat = c;
            end
        end
        e = sb.pop_front();
        if (!got) begin
            check("rsp_timeout", 32'd0, 32'd1);
        end else begin
            check("rdata", bus.o_rsp_rdata, e.rd);
            check("err", {31'b0, bus.o_rsp_err}, {31'b0, e.err});
            check("latency", 32'(lat), 32'(e.lat));
            @(posedge clk);
            #1;
            check("rsp_hold", bus.o_rsp_rdata, 32'd0);
        end
    endtask

    logic [2:0]  ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [31:0] w9_before;

    initial begin
        logic [31:0] t;
        logic [2:0]  f;
        logic        we;
        logic [31:0] a;
        for (int i = 0; i < NW; i++) begin
            t = seed_w(i);
            for (int b = 0; b < 4; b++) bm[4*i + b] = t[8*b +: 8];
        end
        bus.i_req_valid  = 1'b0;
        bus.i_req_we     = 1'b0;
        bus.i_req_funct3 = '0;
        bus.i_req_addr   = '0;
        bus.i_req_wdata  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'b0, bus.o_req_ready}, 32'd1);
        check("rst_valid", {31'b0, bus.o_rsp_valid}, 32'd0);
        check("rst_mem", {mem_wdata[27:0], mem_wren, mem_bmask[2:0]} |
              {23'b0, mem_addr} | {28'b0, mem_bmask}, 32'd0);
        check("rst_rsp", bus.o_rsp_rdata | {31'b0, bus.o_rsp_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        wlog.delete();
        access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        check("sw_nwr", 32'(wlog.size()), 32'd1);
        if (wlog.size() == 1) begin
            check("sw_addr", 32'(wlog[0].a), 32'd4);
            check("sw_mask", 32'(wlog[0].m), 32'hF);
            check("sw_data", wlog[0].d, 32'hDEADBEEF);
        end
        access(1'b0, 3'b010, 32'h10, 32'h0);

        wlog.delete();
        access(1'b1, 3'b000, 32'h13, 32'h80);
        check("sb_nwr", 32'(wlog.size()), 32'd1);
        if (wlog.size() == 1) begin
            check("sb_mask", 32'(wlog[0].m), 32'h8);
            check("sb_data", wlog[0].d, 32'h80000000);
        end
        access(1'b0, 3'b000, 32'h13, 32'h0);
        access(1'b0, 3'b100, 32'h13, 32'h0);

        wlog.delete();
        access(1'b1, 3'b010, 32'h0E, 32'h11223344);
        check("ssw_nwr", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            check("ssw0_a", 32'(wlog[0].a), 32'd3);
            check("ssw0_m", 32'(wlog[0].m), 32'hC);
            check("ssw0_d", wlog[0].d, 32'h33440000);
            check("ssw1_a", 32'(wlog[1].a), 32'd4);
            check("ssw1_m", 32'(wlog[1].m), 32'h3);
            check("ssw1_d", wlog[1].d, 32'h00001122);
        end
        access(1'b0, 3'b010, 32'h0E, 32'h0);
        check("lw_split_lit", bus.o_rsp_rdata, 32'h0);

        wlog.delete();
        access(1'b0, 3'b001, 32'h7FF, 32'h0);
        access(1'b0, 3'b011, 32'h20, 32'h0);
        access(1'b0, 3'b010, 32'h800, 32'h0);
        access(1'b1, 3'b010, 32'h7FE, 32'h55667788);
        access(1'b1, 3'b100, 32'h40, 32'h12345678);
        check("err_nwr", 32'(wlog.size()), 32'd0);
        access(1'b0, 3'b010, 32'h7FC, 32'h0);
        access(1'b0, 3'b101, 32'h7FE, 32'h0);

        for (int n = 0; n < 80; n++) begin
            we = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       a = 32'h7FC + $urandom_range(0, 3);
                1:       a = 32'h800 << $urandom_range(0, 20);
                default: a = $urandom_range(0, 255);
            endcase
            if ($urandom_range(0, 9) == 0)
                f = 3'($urandom_range(0, 7));
            else if (we)
                f = 3'($urandom_range(0, 2));
            else
                f = ld_f3[$urandom_range(0, 4)];
            access(we, f, a, $urandom);
        end

        w9_before = mem[9];
        wlog.delete();
        @(negedge clk);
        bus.i_req_valid  = 1'b1;
        bus.i_req_we     = 1'b1;
        bus.i_req_funct3 = 3'b010;
        bus.i_req_addr   = 32'h22;
        bus.i_req_wdata  = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        bus.i_req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_ready", {31'b0, bus.o_req_ready}, 32'd1);
        check("mid_valid", {31'b0, bus.o_rsp_valid}, 32'd0);
        check("mid_wren", {31'b0, mem_wren}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("mid_nwr", 32'(wlog.size()), 32'd1);
        check("mid_w8", {16'b0, mem[8][31:16]}, 32'h0000F00D);
        check("mid_w9", mem[9], w9_before);
        bm[32'h22] = 8'h0D;
        bm[32'h23] = 8'hF0;
        @(negedge clk);
        rst_n = 1'b1;
        access(1'b0, 3'b010, 32'h22, 32'h0);
        access(1'b0, 3'b001, 32'h22, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the RISC-V execute stage and the word-organised data `memory` (2^MEM_AW × 32-bit words, byte-lane write mask, combinational read).
- Accepts one byte-addressed load or store at a time over a valid/ready handshake.
- Decodes funct3 into a byte mask and aligns the write data.
- Splits accesses that cross a word boundary into two memory cycles.
- Merges, shifts and sign/zero-extends read data, and returns a single-cycle response.

## Interface
- `MEM_AW`, default 9: memory word-address width. Byte space is 2^(MEM_AW+2) bytes.
- `i_clk`  in  1  clock; all state changes on its rising edge.
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_req_valid`  in  1  request present.
- `o_req_ready`  out  1  unit idle and able to accept a request.
- `i_req_we`  in  1  1 = store, 0 = load.
- `i_req_funct3`  in  3  encodings:
  - loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
  - stores: 000 sb, 001 sh, 010 sw
- `i_req_addr`  in  32  byte address.
- `i_req_wdata`  in  32  store data, right-justified.
- `o_rsp_valid`  out  1  one-cycle completion pulse; loads and stores both pulse.
- `o_rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `o_rsp_err`  out  1  illegal funct3, or any touched byte beyond the memory.
- `o_mem_wren`  out  1  memory write enable.
- `o_mem_bmask`  out  4  byte-lane mask; bit i = bits [8i+7:8i].
- `o_mem_addr`  out  MEM_AW  memory word address.
- `o_mem_wdata`  out  32  lane-aligned write data.
- `i_mem_rdata`  in  32  combinational memory read data for `o_mem_addr`.

## Operation
- **FSM states:** IDLE, FIRST, SECOND, RESP. `o_req_ready` = (state == IDLE).
- **Request capture:** in IDLE, a handshake (`i_req_valid` & `o_req_ready`) registers we, funct3, addr and wdata.
- **Decode:** size s = 1/2/4 bytes; off = addr[1:0]; w0 = addr[MEM_AW+1:2].
- **Split condition:** split = (off + s > 4).
- **Lane mask:** m8 = ((1<<s)-1) << off, 8 bits wide.
  - FIRST uses lanes m8[3:0] at address w0.
  - SECOND uses lanes m8[7:4] at address w0+1.
- **Store data:** d64 = {32'b0, wdata} << 8·off.
  - FIRST drives d64[31:0]; SECOND drives d64[63:32].
  - `o_mem_wren` = we in FIRST and SECOND only.
- **Load data:**
  - lo = `i_mem_rdata` sampled at the end of FIRST; hi = sampled at the end of SECOND (0 if no split).
  - v = ({hi, lo} >> 8·off), keeping the low s bytes.
  - lb/lh sign-extend v; lbu/lhu/lw zero-extend.
- **Errors:** raised when funct3 is illegal for we, when addr[31:MEM_AW+2] ≠ 0, or when split and w0 is the last word.
  - Go IDLE→RESP directly, with no memory cycle and no `o_mem_wren`.
  - Drive `o_rsp_err` = 1 and `o_rsp_rdata` = 0.
- **Transitions:**
  - IDLE→FIRST on handshake (no error).
  - FIRST→SECOND if split, else FIRST→RESP.
  - SECOND→RESP.
  - RESP→IDLE unconditionally; there is no response back-pressure.
- **Memory outputs outside FIRST/SECOND:** `o_mem_wren`, `o_mem_bmask`, `o_mem_addr` and `o_mem_wdata` are all 0.

## Timing
- **Reset values:** while `i_reset` = 0, state = IDLE and `o_req_ready` = 1. All other outputs are 0.
- **Aligned access:** handshake at edge k → FIRST during cycle k+1 → `o_rsp_valid` during cycle k+2.
- **Split access:** handshake at edge k → FIRST (k+1) → SECOND (k+2) → `o_rsp_valid` at k+3.
- **Error response:** `o_rsp_valid` during cycle k+1.
- **Store commit:** each memory write commits at the rising edge ending FIRST or SECOND.
- **Request pacing:** `o_req_ready` is low from k+1 until RESP ends. The next handshake is possible in the cycle after RESP, giving at most one request per 3 cycles (aligned).
- **Response hold:** `o_rsp_rdata` and `o_rsp_err` are valid only while `o_rsp_valid` = 1, and hold 0 otherwise.
- **Reset mid-operation:** returns immediately to IDLE and abandons the response.
  - A FIRST-half store write already committed stays in memory.
  - The SECOND half is never written.

## Structure
- **Package `lsu_pkg`:**
  - funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW)
  - state enum `lsu_state_e`
  - function `size_of(funct3)`
  - function `illegal(we, funct3)`
- **Sub-module `lsu_align`:** purely combinational.
  - Inputs: off, s, funct3, wdata, lo, hi.
  - Outputs: m8, d64, extended load value.
- **Top level:** keeps the FSM, request registers and the lo/hi capture registers.

## Test plan
- Reset asserted mid-split-store after FIRST → no SECOND write, ready = 1, rsp_valid = 0, and the first-half bytes are present in memory.
- sw 0xDEADBEEF @0x0000_0010, then lw @0x10 → single write with bmask 1111 at word 4; load response 0xDEADBEEF 2 cycles after accept; err = 0.
- sb 0x80 @0x13, then lb @0x13 → 0xFFFFFF80 and lbu → 0x00000080; write bmask 1000 with wdata 0x80000000.
- sw 0x11223344 @0x0E (split) → FIRST word 3 bmask 1100 wdata 0x33440000, SECOND word 4 bmask 0011 wdata 0x00001122; lw @0x0E returns 0x11223344 at k+3.
- lh @0x7FF (last byte of 2 KiB) → err = 1 at k+1 with no memory access; funct3 = 011 load → err = 1; address 0x800 → err = 1.
